// File: rtl/mc_pkg.sv
// Shared state encoding, instruction constants and control-word layout for
// the multi-cycle MIPS control sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_RTYPE  = 4'd2,
    S_RWB    = 4'd3,
    S_IEXEC  = 4'd4,
    S_IWB    = 4'd5,
    S_MEMRD  = 4'd6,
    S_MRWB   = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_SLT = 5'd5;
  localparam logic [4:0] ALU_LUI = 5'd6;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] branch;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_r;
    logic       mem_w;
    logic       ir_wr;
    logic       reg_w;
    logic       reg_dst;
    logic       mem2r;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_ctrl;
    logic [1:0] ext_op;
  } ctrl_t;

  // ALU_NOP doubles as the "unsupported funct" marker for the sequencer.
  function automatic logic [4:0] funct_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Control-word decoder: maps the current sequencer state (plus the IR fields
// and the fetch handshake) onto the datapath control signals.
module mc_ctrl_dec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_r     = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctrl  = ALU_ADD;
        // IR load and PC+4 only commit once the instruction word is back.
        ctrl.ir_wr     = mem_ready;
        ctrl.pc_wr     = mem_ready;
        ctrl.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.ext_op    = EXT_SIGN;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      S_RTYPE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_ctrl  = funct_alu(funct);
      end
      S_RWB: begin
        ctrl.reg_w = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (op_code)
          OP_ORI: begin
            ctrl.ext_op   = EXT_ZERO;
            ctrl.alu_ctrl = ALU_OR;
          end
          OP_LUI: begin
            ctrl.ext_op   = EXT_UPPER;
            ctrl.alu_ctrl = ALU_LUI;
          end
          default: begin
            ctrl.ext_op   = EXT_SIGN;
            ctrl.alu_ctrl = ALU_ADD;
          end
        endcase
      end
      S_IWB: begin
        ctrl.reg_w   = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_MEMRD: begin
        ctrl.mem_r  = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_MRWB: begin
        ctrl.reg_w   = 1'b1;
        ctrl.reg_dst = 1'b1;
        ctrl.mem2r   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_w  = 1'b1;
        ctrl.i_or_d = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_ctrl   = ALU_SUB;
        ctrl.pc_wr_cond = 1'b1;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = (op_code == OP_BNE) ? BR_NE : BR_EQ;
      end
      S_JUMP: begin
        ctrl.pc_wr  = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: state register, memory-wait timeout
// and registered retire/error pulses around the control-word decoder.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic [1:0] Branch,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemR,
  output logic       MemW,
  output logic       IRWr,
  output logic       RegW,
  output logic       RegDst,
  output logic       Mem2R,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [4:0] Aluctrl,
  output logic [1:0] EXTOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       err
);

  localparam logic [3:0] LAST_WAIT = 4'(MEM_TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] wait_cnt;
  logic       wait_state;
  logic       timeout;
  ctrl_t      ctrl;

  // Zero is consumed by the datapath's branch qualification, not here.
  wire unused_zero = &{1'b0, Zero};

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);
  assign timeout    = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt   <= '0;
      instr_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      err        <= 1'b0;
      if (wait_state && !mem_ready) begin
        // A late mem_ready on the last allowed cycle still wins over the abort.
        if (timeout) begin
          state_q  <= S_FETCH;
          wait_cnt <= '0;
          err      <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= '0;
        case (state_q)
          S_FETCH: state_q <= S_DECODE;
          S_DECODE: begin
            case (OpCode)
              OP_RTYPE:                                state_q <= S_RTYPE;
              OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_LUI:   state_q <= S_IEXEC;
              OP_BEQ, OP_BNE:                          state_q <= S_BRANCH;
              OP_J:                                    state_q <= S_JUMP;
              default: begin
                state_q <= S_FETCH;
                err     <= 1'b1;
              end
            endcase
          end
          S_RTYPE: begin
            if (funct_alu(Funct) == ALU_NOP) begin
              state_q <= S_FETCH;
              err     <= 1'b1;
            end else begin
              state_q <= S_RWB;
            end
          end
          S_IEXEC: begin
            case (OpCode)
              OP_LW:   state_q <= S_MEMRD;
              OP_SW:   state_q <= S_MEMWR;
              default: state_q <= S_IWB;
            endcase
          end
          S_MEMRD: state_q <= S_MRWB;
          S_RWB, S_IWB, S_MRWB, S_MEMWR, S_BRANCH, S_JUMP: begin
            state_q    <= S_FETCH;
            instr_done <= 1'b1;
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

  mc_ctrl_dec u_dec (
    .state     (state_q),
    .op_code   (OpCode),
    .funct     (Funct),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWr     = ctrl.pc_wr;
  assign PCWrCond = ctrl.pc_wr_cond;
  assign Branch   = ctrl.branch;
  assign PCSrc    = ctrl.pc_src;
  assign IorD     = ctrl.i_or_d;
  assign MemR     = ctrl.mem_r;
  assign MemW     = ctrl.mem_w;
  assign IRWr     = ctrl.ir_wr;
  assign RegW     = ctrl.reg_w;
  assign RegDst   = ctrl.reg_dst;
  assign Mem2R    = ctrl.mem2r;
  assign AluSrcA  = ctrl.alu_src_a;
  assign AluSrcB  = ctrl.alu_src_b;
  assign Aluctrl  = ctrl.alu_ctrl;
  assign EXTOp    = ctrl.ext_op;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected state/control/pulse
// records are queued as stimulus is driven and compared as the DUT responds.
module tb_mc_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWr, PCWrCond, IorD, MemR, MemW, IRWr, RegW, RegDst, Mem2R, AluSrcA;
  logic [1:0] Branch, PCSrc, AluSrcB, EXTOp;
  logic [4:0] Aluctrl;
  logic [3:0] state;
  logic       instr_done;
  logic       err;

  mc_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWr       (PCWr),
    .PCWrCond   (PCWrCond),
    .Branch     (Branch),
    .PCSrc      (PCSrc),
    .IorD       (IorD),
    .MemR       (MemR),
    .MemW       (MemW),
    .IRWr       (IRWr),
    .RegW       (RegW),
    .RegDst     (RegDst),
    .Mem2R      (Mem2R),
    .AluSrcA    (AluSrcA),
    .AluSrcB    (AluSrcB),
    .Aluctrl    (Aluctrl),
    .EXTOp      (EXTOp),
    .state      (state),
    .instr_done (instr_done),
    .err        (err)
  );

  localparam logic [3:0] F = 4'd0, D = 4'd1, RT = 4'd2, RWB = 4'd3, IEX = 4'd4,
                         IWB = 4'd5, MRD = 4'd6, MRWB = 4'd7, MWR = 4'd8,
                         BR = 4'd9, JMP = 4'd10;

  typedef struct {
    logic [3:0]  st;
    logic [22:0] ctrl;
    logic        done;
    logic        err;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          step_idx = 0;
  logic [31:0] cur_instr = '0;
  logic        cur_zero = 1'b0;
  logic        pend_done = 1'b0;
  logic        pend_err = 1'b0;
  logic [22:0] dut_ctrl;

  assign dut_ctrl = {PCWr, PCWrCond, Branch, PCSrc, IorD, MemR, MemW, IRWr, RegW,
                     RegDst, Mem2R, AluSrcA, AluSrcB, Aluctrl, EXTOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control word per state, written straight from the state table.
  function automatic logic [22:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic mr);
    logic pcwr, pcwrc, iord, memr, memw, irwr, regw, regdst, m2r, srca;
    logic [1:0] br, pcsrc, srcb, ext;
    logic [4:0] alu;
    {pcwr, pcwrc, iord, memr, memw, irwr, regw, regdst, m2r, srca} = '0;
    {br, pcsrc, srcb, ext} = '0;
    alu = 5'd0;
    case (st)
      F:    begin memr = 1; srcb = 2'b01; alu = 5'd1; irwr = mr; pcwr = mr; end
      D:    begin srcb = 2'b11; ext = 2'b01; alu = 5'd1; end
      RT: begin
        srca = 1;
        case (fn)
          6'h20: alu = 5'd1;
          6'h22: alu = 5'd2;
          6'h24: alu = 5'd3;
          6'h25: alu = 5'd4;
          6'h2A: alu = 5'd5;
          default: alu = 5'd0;
        endcase
      end
      RWB:  regw = 1;
      IEX: begin
        srca = 1; srcb = 2'b10;
        if (op == 6'h0D) begin ext = 2'b00; alu = 5'd4; end
        else if (op == 6'h0F) begin ext = 2'b10; alu = 5'd6; end
        else begin ext = 2'b01; alu = 5'd1; end
      end
      IWB:  begin regw = 1; regdst = 1; end
      MRD:  begin memr = 1; iord = 1; end
      MRWB: begin regw = 1; regdst = 1; m2r = 1; end
      MWR:  begin memw = 1; iord = 1; end
      BR: begin
        srca = 1; alu = 5'd2; pcwrc = 1; pcsrc = 2'b01;
        br = (op == 6'h05) ? 2'b10 : 2'b01;
      end
      JMP:  begin pcwr = 1; pcsrc = 2'b10; end
      default: ;
    endcase
    return {pcwr, pcwrc, br, pcsrc, iord, memr, memw, irwr, regw, regdst, m2r, srca,
            srcb, alu, ext};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic cycleStep(input logic [3:0] st, input logic mr);
    exp_t e;
    @(negedge clk);
    mem_ready = mr;
    Zero      = cur_zero;
    OpCode    = cur_instr[31:26];
    Funct     = cur_instr[5:0];
    e.st   = st;
    e.ctrl = exp_ctrl(st, cur_instr[31:26], cur_instr[5:0], mr);
    e.done = pend_done;
    e.err  = pend_err;
    e.idx  = step_idx;
    step_idx++;
    exp_q.push_back(e);
    pend_done = 1'b0;
    pend_err  = 1'b0;
  endtask

  // Fifteen low cycles in a wait state abort; ready on the fifteenth still succeeds.
  task automatic waitPhase(input logic [3:0] st, input int waits, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k < waits) begin
        cycleStep(st, 1'b0);
      end else begin
        cycleStep(st, 1'b1);
        ok = 1'b1;
        return;
      end
    end
    pend_err = 1'b1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input int fwait, input int mwait,
                               input logic z);
    bit ok;
    logic [5:0] op;
    logic [5:0] fn;
    cur_instr = instr;
    cur_zero  = z;
    op = instr[31:26];
    fn = instr[5:0];
    waitPhase(F, fwait, ok);
    if (!ok) return;
    cycleStep(D, rnd());
    case (op)
      6'h00: begin
        cycleStep(RT, rnd());
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          cycleStep(RWB, rnd());
          pend_done = 1'b1;
        end else begin
          pend_err = 1'b1;
        end
      end
      6'h23: begin
        cycleStep(IEX, rnd());
        waitPhase(MRD, mwait, ok);
        if (ok) begin
          cycleStep(MRWB, rnd());
          pend_done = 1'b1;
        end
      end
      6'h2B: begin
        cycleStep(IEX, rnd());
        waitPhase(MWR, mwait, ok);
        if (ok) pend_done = 1'b1;
      end
      6'h08, 6'h0D, 6'h0F: begin
        cycleStep(IEX, rnd());
        cycleStep(IWB, rnd());
        pend_done = 1'b1;
      end
      6'h04, 6'h05: begin
        cycleStep(BR, rnd());
        pend_done = 1'b1;
      end
      6'h02: begin
        cycleStep(JMP, rnd());
        pend_done = 1'b1;
      end
      default: pend_err = 1'b1;
    endcase
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_state"}, {28'd0, state}, 32'd0);
    checkOutput({tag, "_memw"},  {31'd0, MemW}, 32'd0);
    checkOutput({tag, "_regw"},  {31'd0, RegW}, 32'd0);
    checkOutput({tag, "_done"},  {31'd0, instr_done}, 32'd0);
    checkOutput({tag, "_err"},   {31'd0, err}, 32'd0);
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput($sformatf("state#%0d", mon_e.idx), {28'd0, state}, {28'd0, mon_e.st});
      checkOutput($sformatf("ctrl#%0d", mon_e.idx), {9'd0, dut_ctrl}, {9'd0, mon_e.ctrl});
      checkOutput($sformatf("done#%0d", mon_e.idx), {31'd0, instr_done}, {31'd0, mon_e.done});
      checkOutput($sformatf("err#%0d", mon_e.idx), {31'd0, err}, {31'd0, mon_e.err});
    end
  end

  initial begin
    rst = 1'b1; OpCode = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkReset("rst_init");
    checkOutput("rst_init_ctrl", {9'd0, dut_ctrl}, {9'd0, exp_ctrl(F, 6'h00, 6'h00, 1'b0)});
    rst = 1'b0;

    $display("[TB] R-type arithmetic");
    applyStimulus(32'h00221820, 0, 0, 1'b0);
    applyStimulus(32'h00221822, 0, 0, 1'b0);
    applyStimulus(32'h00221824, 1, 0, 1'b0);
    applyStimulus(32'h00221825, 0, 0, 1'b0);
    applyStimulus(32'h0022182A, 0, 0, 1'b0);

    $display("[TB] loads, stores and immediates");
    applyStimulus(32'h8C220004, 0, 2, 1'b0);
    applyStimulus(32'h8C220004, 3, 0, 1'b0);
    applyStimulus(32'hAC220004, 0, 0, 1'b0);
    applyStimulus(32'hAC220004, 0, 4, 1'b0);
    applyStimulus(32'h20220005, 0, 0, 1'b0);
    applyStimulus(32'h34220005, 0, 0, 1'b0);
    applyStimulus(32'h3C020005, 0, 0, 1'b0);

    $display("[TB] branches and jump");
    applyStimulus(32'h10220003, 0, 0, 1'b1);
    applyStimulus(32'h14220003, 0, 0, 1'b0);
    applyStimulus(32'h14220003, 0, 0, 1'b1);
    applyStimulus(32'h08000010, 0, 0, 1'b0);

    $display("[TB] illegal encodings");
    applyStimulus(32'hFC000000, 0, 0, 1'b0);
    applyStimulus(32'h00200008, 0, 0, 1'b0);

    $display("[TB] wait boundaries and timeouts");
    applyStimulus(32'h8C220004, 0, 14, 1'b0);
    applyStimulus(32'hAC220004, 14, 0, 1'b0);
    applyStimulus(32'hAC220004, 0, 40, 1'b0);
    applyStimulus(32'h00221820, 20, 0, 1'b0);
    applyStimulus(32'h8C220004, 0, 15, 1'b0);
    applyStimulus(32'h00221820, 0, 0, 1'b0);

    $display("[TB] reset during store");
    cur_instr = 32'hAC220004;
    cur_zero  = 1'b0;
    cycleStep(F, 1'b1);
    cycleStep(D, rnd());
    cycleStep(IEX, rnd());
    cycleStep(MWR, 1'b0);
    cycleStep(MWR, 1'b0);
    @(negedge clk);
    #3;
    checkOutput("pre_rst_state", {28'd0, state}, {28'd0, MWR});
    rst = 1'b1;
    #1;
    checkReset("rst_mid");
    repeat (2) begin
      @(negedge clk);
      #1;
      checkReset("rst_hold");
    end
    rst = 1'b0;
    pend_done = 1'b0;
    pend_err  = 1'b0;
    applyStimulus(32'h08000010, 0, 0, 1'b0);
    cycleStep(F, 1'b0);

    repeat (2) @(negedge clk);
    #3;
    checkOutput("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
